// File: rtl/iter_shifter_if.sv
// Request/response bundle for the iterative shifter.
// Valid/ready on both sides; busy rides along for status.
interface iter_shifter_if #(
    parameter int WIDTH = 16,
    parameter int CNT_W = $clog2(WIDTH)
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] In;
    logic [CNT_W-1:0] Cnt;
    logic [1:0]       Op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] Out;
    logic             busy;

    modport master (
        output in_valid, In, Cnt, Op, out_ready,
        input  in_ready, out_valid, Out, busy
    );

    modport slave (
        input  in_valid, In, Cnt, Op, out_ready,
        output in_ready, out_valid, Out, busy
    );
endinterface

// File: rtl/iter_shifter.sv
// Multi-cycle rotate/shift unit: one bit position per clock.
// Ops: 00 rll, 01 sll, 10 ror, 11 srl.
module iter_shifter #(
    parameter int WIDTH = 16,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input logic clk,
    input logic rst_n,
    iter_shifter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] data_reg, data_nx;
    logic [CNT_W-1:0] rem, rem_nx;
    logic [1:0]       op_reg, op_nx;
    logic [WIDTH-1:0] stepped;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            data_reg <= '0;
            rem      <= '0;
            op_reg   <= '0;
        end else begin
            state    <= state_nx;
            data_reg <= data_nx;
            rem      <= rem_nx;
            op_reg   <= op_nx;
        end
    end

    // Single-bit step for the latched op
    always_comb begin
        stepped = data_reg;
        case (op_reg)
            2'b00:   stepped = {data_reg[WIDTH-2:0], data_reg[WIDTH-1]};
            2'b01:   stepped = {data_reg[WIDTH-2:0], 1'b0};
            2'b10:   stepped = {data_reg[0], data_reg[WIDTH-1:1]};
            default: stepped = {1'b0, data_reg[WIDTH-1:1]};
        endcase
    end

    always_comb begin
        state_nx = state;
        data_nx  = data_reg;
        rem_nx   = rem;
        op_nx    = op_reg;
        case (state)
            IDLE: begin
                if (bus.in_valid) begin
                    data_nx  = bus.In;
                    rem_nx   = bus.Cnt;
                    op_nx    = bus.Op;
                    state_nx = (bus.Cnt == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                data_nx = stepped;
                rem_nx  = rem - CNT_W'(1);
                if (rem == CNT_W'(1))
                    state_nx = DONE;
            end
            DONE: begin
                if (bus.out_ready)
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.busy      = (state != IDLE);
    assign bus.Out       = data_reg;
endmodule

// File: tb/tb_iter_shifter.sv
// Randomised scoreboard bench for iter_shifter (WIDTH=16).
// Expected results are queued at issue; a monitor pops on handshake.
module tb_iter_shifter;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    iter_shifter_if #(.WIDTH(16)) bus ();
    iter_shifter #(.WIDTH(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int npass = 0;
    int ntot  = 0;
    logic [15:0] expq[$];

    task automatic chk(input string n, input logic [31:0] a,
                       input logic [31:0] e);
        ntot++;
        if (a === e) npass++;
        else $display("FAIL %s got=%h want=%h", n, a, e);
    endtask

    // Reference: whole-amount shift/rotate by arithmetic
    function automatic logic [15:0] model(input logic [1:0] op,
                                          input logic [15:0] d,
                                          input int n);
        logic [31:0] x, r;
        x = {16'h0, d};
        case (op)
            2'd0:    r = (x << n) | (x >> (16 - n));
            2'd1:    r = x << n;
            2'd2:    r = (x >> n) | (x << (16 - n));
            default: r = x >> n;
        endcase
        return r[15:0];
    endfunction

    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            if (expq.size() == 0) chk("unexpected_result", bus.Out, 32'hDEAD);
            else chk("result", bus.Out, expq.pop_front());
        end
    end

    // Called and returns at posedge+1
    task automatic send(input logic [1:0] op, input logic [15:0] d,
                        input logic [3:0] c, input logic [15:0] e,
                        input bit hold);
        int lat;
        int t;
        bit ok;
        t = 0;
        while (!bus.in_ready && t < 50) begin
            @(posedge clk); #1; t++;
        end
        chk("ready_wait", bus.in_ready, 1);
        bus.in_valid = 1'b1;
        bus.In = d;
        bus.Cnt = c;
        bus.Op = op;
        expq.push_back(e);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.In = 16'($urandom);
        bus.Cnt = 4'($urandom);
        bus.Op = 2'($urandom);
        lat = 0;
        ok = 1'b1;
        do begin
            @(negedge clk);
            lat++;
            if (!bus.out_valid && (!bus.busy || bus.in_ready)) ok = 1'b0;
        end while (!bus.out_valid && lat < 40);
        chk("latency", lat, 32'(c) + 1);
        if (c != 0) chk("busy_in_flight", ok, 1);
        if (hold) begin
            for (int i = 0; i < 3; i++) begin
                @(posedge clk); #1;
                bus.in_valid = 1'b1;
                bus.In = 16'($urandom);
                bus.Cnt = 4'd0;
                @(negedge clk);
                chk("bp_out_stable", bus.Out, e);
                chk("bp_in_ready", bus.in_ready, 0);
            end
            @(posedge clk); #1;
            bus.in_valid = 1'b0;
            bus.out_ready = 1'b1;
            @(posedge clk); #1;
            @(negedge clk);
            chk("idle_after_bp", bus.in_ready, 1);
            @(posedge clk); #1;
        end else begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout got=1 want=0");
        $fatal(1, "timeout");
    end

    initial begin
        logic [1:0] op;
        logic [15:0] d;
        logic [3:0] c;
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.In = '0;
        bus.Cnt = '0;
        bus.Op = '0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_out", bus.Out, 0);
        @(posedge clk); #1;

        send(2'd2, 16'h8001, 4'd1, 16'hC000, 0);
        send(2'd0, 16'h1234, 4'd4, 16'h2341, 0);
        send(2'd3, 16'h8000, 4'd15, 16'h0001, 0);
        send(2'd1, 16'hFFFF, 4'd8, 16'hFF00, 0);
        send(2'd0, 16'h00F0, 4'd15, 16'h0078, 0);
        send(2'd1, 16'h8001, 4'd15, 16'h8000, 0);
        for (int i = 0; i < 4; i++)
            send(2'(i), 16'hA5A5, 4'd0, 16'hA5A5, 0);

        bus.out_ready = 1'b0;
        send(2'd2, 16'h00FF, 4'd4, 16'hF00F, 1);
        send(2'd0, 16'h0F0F, 4'd2, 16'h3C3C, 0);

        bus.in_valid = 1'b1;
        bus.In = 16'h00FF;
        bus.Cnt = 4'd10;
        bus.Op = 2'd2;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_out_valid", bus.out_valid, 0);
        chk("midrst_out", bus.Out, 0);
        chk("midrst_in_ready", bus.in_ready, 1);
        chk("midrst_busy", bus.busy, 0);
        @(posedge clk); #1;
        send(2'd0, 16'h0001, 4'd3, 16'h0008, 0);

        for (int i = 0; i < 40; i++) begin
            op = 2'($urandom_range(3));
            d = 16'($urandom);
            c = 4'($urandom_range(15));
            send(op, d, c, model(op, d, int'(c)), 0);
            repeat ($urandom_range(2)) begin
                @(posedge clk); #1;
            end
        end

        repeat (3) @(posedge clk);
        chk("queue_drained", expq.size(), 0);
        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule
